// File: rtl/lc_resp_pkg.sv
// Shared types and constants for the lower-level cache line responder.
package lc_resp_pkg;

    localparam int LINE_BITS     = 512;
    // Queue entries carry a generously sized address; the top keeps the low PADDR_BITS.
    localparam int ADDR_MAX_BITS = 64;
    localparam int CNT_BITS      = 8;

    // Request-stall LFSR: 8-bit Fibonacci, taps 8,6,5,4 (bit positions 7,5,4,3).
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef struct packed {
        logic [ADDR_MAX_BITS-1:0] addr;
        logic [LINE_BITS-1:0]     data;
        logic [CNT_BITS-1:0]      cnt;
    } lc_rd_entry_t;

endpackage

// File: rtl/lc_resp_fifo.sv
// Pending-read FIFO: strict order, every entry's countdown ticks down each cycle.
module lc_resp_fifo
    import lc_resp_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         push_i,
    input  lc_rd_entry_t push_data_i,
    input  logic         pop_i,
    output lc_rd_entry_t head_o,
    output logic [CW-1:0] count_o
);

    lc_rd_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, wr_q;
    logic [CW-1:0] cnt_q, cnt_d;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Saturating countdown on all slots; a push overwrites its slot with a fresh count.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].cnt != '0) mem_q[i].cnt <= mem_q[i].cnt - 1'b1;
        end
        if (push_i) mem_q[wr_q] <= push_data_i;
    end

    // Occupancy follows push/pop; both on one edge leave it unchanged.
    always_comb begin
        cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= nxt(wr_q);
            if (pop_i)  rd_q <= nxt(rd_q);
            cnt_q <= cnt_d;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/lc_line_responder.sv
// Line-granular backing store answering L1D line reads after a fixed latency.
// Optional request backpressure injection: define LC_RESP_STALL_EN.
module lc_line_responder
    import lc_resp_pkg::*;
#(
    parameter int PADDR_BITS    = 22,
    parameter int B             = 64,
    parameter int MEM_LINE_BITS = 8,
    parameter int DEPTH         = 4,
    parameter int LATENCY       = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_N_in,
    input  logic                  l1_valid_in,
    output logic                  l1_ready_out,
    input  logic [PADDR_BITS-1:0] l1_addr_in,
    input  logic [LINE_BITS-1:0]  l1_value_in,
    input  logic                  l1_we_in,
    output logic                  l1_valid_out,
    input  logic                  l1_ready_in,
    output logic [PADDR_BITS-1:0] l1_addr_out,
    output logic [LINE_BITS-1:0]  l1_value_out,
    output logic                  idle_out
);

    localparam int OFF_BITS = $clog2(B);
    localparam int LINES    = 1 << MEM_LINE_BITS;
    localparam int CW       = $clog2(DEPTH + 1);

    logic [LINE_BITS-1:0]     store_q [LINES];
    logic [LINES-1:0]         written_q;
    logic                     rsp_vld_q;
    logic [PADDR_BITS-1:0]    rsp_addr_q;
    logic [LINE_BITS-1:0]     rsp_data_q;

    logic [CW-1:0]            q_cnt;
    lc_rd_entry_t             head, push_ent;
    logic                     can_accept, accept, wr_acc, rd_acc, launch;
    logic [MEM_LINE_BITS-1:0] idx;
    logic [PADDR_BITS-1:0]    aligned;
    logic                     unused_bits;

    assign idx         = l1_addr_in[OFF_BITS +: MEM_LINE_BITS];
    assign aligned     = {l1_addr_in[PADDR_BITS-1:OFF_BITS], {OFF_BITS{1'b0}}};
    assign unused_bits = ^{l1_addr_in[OFF_BITS-1:0], head.addr[ADDR_MAX_BITS-1:PADDR_BITS]};

    assign can_accept = (q_cnt < CW'(DEPTH));

`ifdef LC_RESP_STALL_EN
    logic [7:0] lfsr_q;

    // Free-running LFSR; its low bits randomly withhold request ready.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) lfsr_q <= LFSR_SEED;
        else           lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    assign l1_ready_out = can_accept && (lfsr_q[1:0] != 2'b00);
`else
    assign l1_ready_out = can_accept;
`endif

    assign accept = l1_valid_in && l1_ready_out;
    assign wr_acc = accept && l1_we_in;
    assign rd_acc = accept && !l1_we_in;

    // The countdown holds the number of edges still to pass before the launch edge,
    // so a read accepted at edge k launches at edge k+LATENCY.
    always_comb begin
        push_ent      = '0;
        push_ent.addr = ADDR_MAX_BITS'(aligned);
        push_ent.data = written_q[idx] ? store_q[idx] : '0;
        push_ent.cnt  = CNT_BITS'(LATENCY - 1);
    end

    // Head leaves the queue once its time is up and the response slot is free or freeing.
    assign launch = (q_cnt != '0) && (head.cnt == '0) && (!rsp_vld_q || l1_ready_in);

    lc_resp_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i       (clk_in),
        .rst_n_i     (rst_N_in),
        .push_i      (rd_acc),
        .push_data_i (push_ent),
        .pop_i       (launch),
        .head_o      (head),
        .count_o     (q_cnt)
    );

    // Line data array; contents are meaningful only where the written bit is set.
    always_ff @(posedge clk_in) begin
        if (wr_acc) store_q[idx] <= l1_value_in;
    end

    // Written bits gate reads of never-written lines to zero.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in)   written_q      <= '0;
        else if (wr_acc) written_q[idx] <= 1'b1;
    end

    // Response register: holds steady until consumed, reloads on launch.
    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            rsp_vld_q  <= 1'b0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
        end else if (launch) begin
            rsp_vld_q  <= 1'b1;
            rsp_addr_q <= head.addr[PADDR_BITS-1:0];
            rsp_data_q <= head.data;
        end else if (rsp_vld_q && l1_ready_in) begin
            rsp_vld_q  <= 1'b0;
        end
    end

    assign l1_valid_out = rsp_vld_q;
    assign l1_addr_out  = rsp_addr_q;
    assign l1_value_out = rsp_data_q;
    assign idle_out     = (q_cnt == '0) && !rsp_vld_q;

endmodule

// File: tb/tb_lc_line_responder.sv
// Bench for lc_line_responder: directed table, corner sequences, random traffic vs model.
module tb_lc_line_responder;

    localparam int DEPTH = 4;
    localparam int LAT   = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         l1_valid_in, l1_we_in, l1_ready_in;
    logic [21:0]  l1_addr_in;
    logic [511:0] l1_value_in;
    logic         l1_ready_out, l1_valid_out, idle_out;
    logic [21:0]  l1_addr_out;
    logic [511:0] l1_value_out;

    always #5 clk = ~clk;

    lc_line_responder dut (
        .clk_in       (clk),
        .rst_N_in     (rst_n),
        .l1_valid_in  (l1_valid_in),
        .l1_ready_out (l1_ready_out),
        .l1_addr_in   (l1_addr_in),
        .l1_value_in  (l1_value_in),
        .l1_we_in     (l1_we_in),
        .l1_valid_out (l1_valid_out),
        .l1_ready_in  (l1_ready_in),
        .l1_addr_out  (l1_addr_out),
        .l1_value_out (l1_value_out),
        .idle_out     (idle_out)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: reads waiting with their accept edge, a line map, and the
    // response currently on offer.
    typedef struct { logic [21:0] addr; logic [511:0] data; int t; } pend_t;
    pend_t        pq[$];
    logic [511:0] mstore [int];
    bit           m_vld;
    logic [21:0]  m_addr;
    logic [511:0] m_data;
    int           edge_n = 0;

    typedef struct {
        bit           we;
        logic [21:0]  addr;
        logic [511:0] wdata;
        logic [21:0]  exp_addr;
        logic [511:0] exp_data;
    } vec_t;

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic int line_of(input logic [21:0] a);
        return int'((a >> 6) & 22'hFF);
    endfunction

    task automatic model_check();
        chk("ready", 512'(l1_ready_out), 512'(pq.size() < DEPTH));
        chk("valid", 512'(l1_valid_out), 512'(m_vld));
        chk("idle",  512'(idle_out),     512'(pq.size() == 0 && !m_vld));
        if (m_vld) begin
            chk("addr", 512'(l1_addr_out), 512'(m_addr));
            chk("data", l1_value_out, m_data);
        end
    endtask

    // One clock: drive inputs just after a falling edge, advance the model at the
    // rising edge, compare at the next falling edge.
    task automatic step(input bit v, input bit we, input logic [21:0] a,
                        input logic [511:0] d, input bit rin);
        bit acc;
        int ln;
        l1_valid_in = v; l1_we_in = we; l1_addr_in = a; l1_value_in = d; l1_ready_in = rin;
        acc = v && (pq.size() < DEPTH);
        @(posedge clk);
        edge_n++;
        if (m_vld && rin) m_vld = 1'b0;
        if (!m_vld && pq.size() > 0 && edge_n >= pq[0].t + LAT) begin
            m_vld  = 1'b1;
            m_addr = pq[0].addr;
            m_data = pq[0].data;
            void'(pq.pop_front());
        end
        if (acc) begin
            ln = line_of(a);
            if (we) mstore[ln] = d;
            else    pq.push_back('{a & 22'h3FFFC0, mstore.exists(ln) ? mstore[ln] : 512'h0, edge_n});
        end
        @(negedge clk);
        model_check();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        l1_valid_in = 1'b0; l1_we_in = 1'b0; l1_addr_in = '0; l1_value_in = '0; l1_ready_in = 1'b0;
        #2;
        chk("rst_valid", 512'(l1_valid_out), 512'h0);
        chk("rst_ready", 512'(l1_ready_out), 512'h1);
        chk("rst_idle",  512'(idle_out),     512'h1);
        chk("rst_addr",  512'(l1_addr_out),  512'h0);
        chk("rst_data",  l1_value_out,       512'h0);
        pq.delete();
        mstore.delete();
        m_vld = 1'b0; m_addr = '0; m_data = '0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Idle cycles with response ready high; reports the first response seen.
    task automatic wait_rsp(input int maxc, output int lat, output logic [21:0] a,
                            output logic [511:0] d);
        lat = -1; a = '0; d = '0;
        for (int j = 1; j <= maxc; j++) begin
            step(1'b0, 1'b0, 22'h0, 512'h0, 1'b1);
            if (l1_valid_out && lat < 0) begin
                lat = j; a = l1_addr_out; d = l1_value_out;
            end
        end
    endtask

    initial begin
        vec_t         vt[6];
        logic [21:0]  sa[4];
        logic [511:0] sv[4];
        logic [21:0]  ea[5];
        logic [511:0] ed[5];
        int           lat;
        logic [21:0]  ra;
        logic [511:0] rd;

        rst_n = 1'b0;
        l1_valid_in = 1'b0; l1_we_in = 1'b0; l1_addr_in = '0; l1_value_in = '0; l1_ready_in = 1'b0;
        @(negedge clk);
        do_reset();

        // ---- table of single transactions ----
        vt[0] = '{1'b0, 22'h060300, 512'h0,        22'h060300, 512'h0};
        vt[1] = '{1'b1, 22'h004040, 512'hDEADBEEF, 22'h0,      512'h0};
        vt[2] = '{1'b0, 22'h004050, 512'h0,        22'h004040, 512'hDEADBEEF};
        vt[3] = '{1'b1, 22'h003FC0, 512'h55,       22'h0,      512'h0};
        vt[4] = '{1'b0, 22'h013FC5, 512'h0,        22'h013FC0, 512'h55};
        vt[5] = '{1'b0, 22'h001234, 512'h0,        22'h001200, 512'h0};
        for (int i = 0; i < 6; i++) begin
            step(1'b1, vt[i].we, vt[i].addr, vt[i].wdata, 1'b1);
            wait_rsp(8, lat, ra, rd);
            if (vt[i].we) begin
                chk("wr_no_rsp", 512'(lat), 512'(-1));
            end else begin
                chk("rd_latency", 512'(lat), 512'(LAT));
                chk("rd_addr",    512'(ra),  512'(vt[i].exp_addr));
                chk("rd_data",    rd,        vt[i].exp_data);
            end
        end

        // ---- fill queue behind a stalled response, then drain in order ----
        sa = '{22'h005000, 22'h007000, 22'h009000, 22'h00F000};
        sv = '{512'h1111, 512'h2222, 512'h3333, 512'h4444};
        step(1'b1, 1'b0, 22'h060300, 512'h0, 1'b0);
        for (int i = 0; i < LAT; i++) step(1'b0, 1'b0, 22'h0, 512'h0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b1, sa[i], sv[i], 1'b0);
            step(1'b1, 1'b0, sa[i], 512'h0, 1'b0);
        end
        chk("full_ready_low", 512'(l1_ready_out), 512'h0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 22'h0, 512'h0, 1'b0);
            chk("stall_valid", 512'(l1_valid_out), 512'h1);
            chk("stall_addr",  512'(l1_addr_out),  512'h060300);
            chk("stall_data",  l1_value_out,       512'h0);
        end
        ea = '{22'h060300, 22'h005000, 22'h007000, 22'h009000, 22'h00F000};
        ed = '{512'h0, 512'h1111, 512'h2222, 512'h3333, 512'h4444};
        for (int i = 0; i < 5; i++) begin
            chk("drain_valid", 512'(l1_valid_out), 512'h1);
            chk("drain_addr",  512'(l1_addr_out),  512'(ea[i]));
            chk("drain_data",  l1_value_out,       ed[i]);
            step(1'b0, 1'b0, 22'h0, 512'h0, 1'b1);
        end
        chk("drain_done", 512'(l1_valid_out), 512'h0);

        // ---- read snapshot precedes a following write to the same line ----
        step(1'b1, 1'b0, 22'h002000, 512'h0, 1'b1);
        step(1'b1, 1'b1, 22'h002000, 512'h1, 1'b1);
        wait_rsp(8, lat, ra, rd);
        chk("snap_addr", 512'(ra), 512'h2000);
        chk("snap_data", rd,       512'h0);
        step(1'b1, 1'b0, 22'h002000, 512'h0, 1'b1);
        wait_rsp(8, lat, ra, rd);
        chk("after_wr_data", rd, 512'h1);

        // ---- reset with reads in flight ----
        step(1'b1, 1'b0, 22'h002000, 512'h0, 1'b1);
        step(1'b1, 1'b0, 22'h004040, 512'h0, 1'b1);
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 1'b0, 22'h0, 512'h0, 1'b1);
            chk("post_rst_valid", 512'(l1_valid_out), 512'h0);
            chk("post_rst_idle",  512'(idle_out),     512'h1);
        end
        step(1'b1, 1'b0, 22'h002000, 512'h0, 1'b1);
        wait_rsp(8, lat, ra, rd);
        chk("post_rst_lat",  512'(lat), 512'(LAT));
        chk("post_rst_data", rd,        512'h0);

        // ---- random traffic against the model ----
        for (int c = 0; c < 3000; c++) begin
            logic [21:0]  a;
            logic [511:0] d;
            a = 22'(($urandom_range(0, 7) << 6) | ($urandom_range(0, 3) << 14) | $urandom_range(0, 63));
            for (int w = 0; w < 16; w++) d[w*32 +: 32] = $urandom();
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 4, a, d, $urandom_range(0, 9) < 7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
